// File: rtl/vga_pkg.sv
// Shared timing constants, Bayer dither table and colour struct for the VGA scanout.
// Contents: default raster timing, pipeline latency, rgb2_t {r,g,b}, bayer4(row, col).
// No ports; imported by vga_scanout and its helpers.
package vga_pkg;

  localparam int H_DISPLAY_DEF = 1220;
  localparam int H_FRONT_DEF   = 30;
  localparam int H_SYNC_DEF    = 183;
  localparam int H_TOTAL_DEF   = 1525;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_TOTAL_DEF   = 525;
  localparam int LAT_DEF       = 16;

  localparam int HW = 11;
  localparam int VW = 10;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb2_t;

  // Standard 4x4 ordered-dither threshold, row = v[1:0], column = h[4:3].
  function automatic logic [3:0] bayer4(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] t;
    case ({row, col})
      4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
      4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
      4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'ha: t = 4'd1;   4'hb: t = 4'd9;
      4'hc: t = 4'd15;  4'hd: t = 4'd7;   4'he: t = 4'd13;  default: t = 4'd5;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/vga_scanout_delay_line.sv
// Async-reset shift register of DEPTH stages, each WIDTH bits wide.
// Ports: clk, rst_n, din (into stage 0), dout (last stage, registered).
// Every stage resets to RESET_VAL so a filling pipeline only ever emits inactive values.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RESET_VAL;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator and pixel output stage for the donut renderer.
// Ports: clk/rst_n; h_count/v_count/frame to renderer; donut_visible/donut_luma back;
// hsync_n/vsync_n/de/r/g/b pins, all registered, LAT cycles behind the counters.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_TOTAL   = H_TOTAL_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_TOTAL   = V_TOTAL_DEF,
  parameter int LAT       = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          frame,
  input  logic          donut_visible,
  input  logic [5:0]    donut_luma,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          de,
  output logic [1:0]    r,
  output logic [1:0]    g,
  output logic [1:0]    b
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_DISPLAY);
  localparam logic [VW-1:0] V_VIS    = VW'(V_DISPLAY);
  localparam logic [HW-1:0] HS_START = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);

  // Raster counters: h, v and frame all wrap on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
      frame   <= 1'b0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      if (v_count == V_LAST) begin
        v_count <= '0;
        frame   <= ~frame;
      end else begin
        v_count <= v_count + 1'b1;
      end
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  logic de_raw, hs_raw, vs_raw;
  assign de_raw = (h_count < H_VIS) && (v_count < V_VIS);
  assign hs_raw = !((h_count >= HS_START) && (h_count < HS_END));
  assign vs_raw = !((v_count >= VS_START) && (v_count < VS_END));

  // Sync/de bundle: the last stage of this line drives the pins directly.
  logic [2:0] sync_d;
  delay_line #(.WIDTH(3), .DEPTH(LAT), .RESET_VAL(3'b011)) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({de_raw, hs_raw, vs_raw}),
    .dout  (sync_d)
  );

  assign de      = sync_d[2];
  assign hsync_n = sync_d[1];
  assign vsync_n = sync_d[0];

  // Colour bundle is one stage shorter; the colour register supplies the last stage.
  logic [4:0] crd_d;
  delay_line #(.WIDTH(5), .DEPTH(LAT-1), .RESET_VAL(5'b0)) u_crd_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({de_raw, v_count[1:0], h_count[4:3]}),
    .dout  (crd_d)
  );

  logic [3:0] bayer_val;
  logic [6:0] dith_sum;
  logic [1:0] q;
  assign bayer_val = bayer4(crd_d[3:2], crd_d[1:0]);
  assign dith_sum  = {1'b0, donut_luma} + {3'b0, bayer_val};
  assign q         = dith_sum[6] ? 2'd3 : dith_sum[5:4];

  rgb2_t rgb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else if (!crd_d[4]) begin
      rgb_q <= '0;
    end else if (donut_visible) begin
      rgb_q <= '{r: q, g: q, b: q};
    end else begin
      rgb_q <= '{r: 2'd0, g: 2'd0, b: 2'd1};
    end
  end

  assign r = rgb_q.r;
  assign g = rgb_q.g;
  assign b = rgb_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a reduced-timing instance (full frames fit the run)
// and a default-timing instance (real line timing), both checked every clock against
// an absolute-cycle-count reference model.
module tb_vga_scanout;

  localparam int LAT = 16;
  // Reduced raster for the small instance
  localparam int SHD = 40, SHF = 6, SHS = 10, SHT = 64;
  localparam int SVD = 12, SVF = 2, SVS = 2, SVT = 20;
  // Default raster for the full instance
  localparam int FHD = 1220, FHF = 30, FHS = 183, FHT = 1525;
  localparam int FVD = 480, FVF = 10, FVS = 2, FVT = 525;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vis;
  logic [5:0] luma;

  logic [10:0] s_h, f_h;
  logic [9:0]  s_v, f_v;
  logic        s_f, f_f, s_hs, f_hs, s_vs, f_vs, s_de, f_de;
  logic [1:0]  s_r, s_g, s_b, f_r, f_g, f_b;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_TOTAL(SHT),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_TOTAL(SVT), .LAT(LAT)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .h_count(s_h), .v_count(s_v), .frame(s_f),
    .donut_visible(vis), .donut_luma(luma), .hsync_n(s_hs), .vsync_n(s_vs),
    .de(s_de), .r(s_r), .g(s_g), .b(s_b)
  );

  vga_scanout dut_f (
    .clk(clk), .rst_n(rst_n), .h_count(f_h), .v_count(f_v), .frame(f_f),
    .donut_visible(vis), .donut_luma(luma), .hsync_n(f_hs), .vsync_n(f_vs),
    .de(f_de), .r(f_r), .g(f_g), .b(f_b)
  );

  typedef struct {
    int e;
    int h, v, f, hs, vs, de, r, g, b;
  } exp_t;

  exp_t qs[$];
  exp_t qf[$];

  int compared   = 0;
  int mismatched = 0;
  int printed    = 0;
  int e_next     = 0;

  // Ordered-dither threshold built recursively from the 2x2 base matrix.
  function automatic int bayer_ref(int row, int col);
    int b2 [4] = '{0, 2, 3, 1};
    return 4 * b2[(row % 2) * 2 + (col % 2)] + b2[(row / 2) * 2 + (col / 2)];
  endfunction

  // Expected state after the e-th clock edge since reset release.
  function automatic exp_t model(int e, int hd, int hf, int hs, int ht,
                                 int vd, int vf, int vs, int vt, bit dv, int dl);
    exp_t x;
    int m, hm, vm, sum, qv;
    x.e = e;
    x.h = e % ht;
    x.v = (e / ht) % vt;
    x.f = (e / (ht * vt)) % 2;
    x.hs = 1; x.vs = 1; x.de = 0; x.r = 0; x.g = 0; x.b = 0;
    if (e >= LAT) begin
      m  = e - LAT;
      hm = m % ht;
      vm = (m / ht) % vt;
      x.de = (hm < hd && vm < vd) ? 1 : 0;
      x.hs = (hm >= hd + hf && hm < hd + hf + hs) ? 0 : 1;
      x.vs = (vm >= vd + vf && vm < vd + vf + vs) ? 0 : 1;
      if (x.de == 1) begin
        if (dv) begin
          sum = dl + bayer_ref(vm % 4, (hm / 8) % 4);
          qv  = (sum > 63) ? 3 : sum / 16;
          x.r = qv; x.g = qv; x.b = qv;
        end else begin
          x.b = 1;
        end
      end
    end
    return x;
  endfunction

  task automatic check(input string tag, input exp_t x, input int h, input int v,
                       input int f, input int hs, input int vs, input int de,
                       input int rr, input int gg, input int bb);
    compared++;
    if (x.h != h || x.v != v || x.f != f || x.hs != hs || x.vs != vs ||
        x.de != de || x.r != rr || x.g != gg || x.b != bb) begin
      mismatched++;
      if (printed < 20) begin
        printed++;
        $display("FAIL %s edge=%0d got h=%0d v=%0d f=%0d hs=%0d vs=%0d de=%0d rgb=%0d%0d%0d required h=%0d v=%0d f=%0d hs=%0d vs=%0d de=%0d rgb=%0d%0d%0d",
                 tag, x.e, h, v, f, hs, vs, de, rr, gg, bb,
                 x.h, x.v, x.f, x.hs, x.vs, x.de, x.r, x.g, x.b);
      end
    end
  endtask

  task automatic check_small(input string tag, input exp_t x);
    check(tag, x, int'(s_h), int'(s_v), int'(s_f), int'(s_hs), int'(s_vs),
          int'(s_de), int'(s_r), int'(s_g), int'(s_b));
  endtask

  task automatic check_full(input string tag, input exp_t x);
    check(tag, x, int'(f_h), int'(f_v), int'(f_f), int'(f_hs), int'(f_vs),
          int'(f_de), int'(f_r), int'(f_g), int'(f_b));
  endtask

  task automatic check_reset(input string tag);
    exp_t x;
    x.e = 0;
    x.h = 0; x.v = 0; x.f = 0; x.hs = 1; x.vs = 1; x.de = 0;
    x.r = 0; x.g = 0; x.b = 0;
    check_small({tag, "_small"}, x);
    check_full({tag, "_full"}, x);
  endtask

  // Monitor: pops one expectation per DUT after every clock edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (qs.size() > 0) begin
        x = qs.pop_front();
        check_small("scan_small", x);
      end
      if (qf.size() > 0) begin
        x = qf.pop_front();
        check_full("scan_full", x);
      end
    end
  end

  // Drive inputs for the upcoming edge and queue what each DUT must show after it.
  task automatic drive_and_push();
    int pick;
    vis  = ($urandom_range(0, 3) != 0);
    pick = $urandom_range(0, 7);
    case (pick)
      0:       luma = 6'd0;
      1:       luma = 6'd63;
      2:       luma = 6'd32;
      3:       luma = 6'd40;
      default: luma = 6'($urandom_range(0, 63));
    endcase
    qs.push_back(model(e_next, SHD, SHF, SHS, SHT, SVD, SVF, SVS, SVT, vis, int'(luma)));
    qf.push_back(model(e_next, FHD, FHF, FHS, FHT, FVD, FVF, FVS, FVT, vis, int'(luma)));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_and_push();
      @(posedge clk);
      #1;
      e_next++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    e_next = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    vis   = 1'b1;
    luma  = 6'd63;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_initial");

    release_reset();
    run(4000);

    // Mid-frame reset: outputs must drop to reset values without waiting for a clock.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");

    release_reset();
    run(2500);

    @(negedge clk);
    #1;
    compared++;
    if (qs.size() + qf.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending required 0", qs.size() + qf.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side consumer for the ray-marched donut renderer. It generates the 1525×525 fast-clock VGA raster (`h_count`, `v_count`, `frame`) that drives the renderer, and takes back the renderer's `donut_visible`/`donut_luma` samples. It delays sync/blanking to match the renderer's latency, dithers 6-bit luma to 2-bit-per-channel RGB with a 4×4 Bayer matrix, and registers all pin-level outputs.

## Interface
Parameters:
- `H_DISPLAY`, 1220, visible fast-clock ticks per line
- `H_FRONT`, 30, front porch ticks
- `H_SYNC`, 183, hsync pulse ticks
- `H_TOTAL`, 1525, ticks per line (back porch = remainder, 92)
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10, front porch lines
- `V_SYNC`, 2, vsync pulse lines
- `V_TOTAL`, 525, lines per frame
- `LAT`, 16, cycles from counter value to pin outputs; legal range 2..32

Ports:
- Reset is `rst_n`, asynchronous, active-low; clock is `clk`.
- `clk`  in  1  fast pixel clock (~48 MHz)
- `rst_n`  in  1  async active-low reset
- `h_count`  out  11  horizontal tick counter, to renderer
- `v_count`  out  10  line counter, to renderer
- `frame`  out  1  frame parity, to renderer
- `donut_visible`  in  1  renderer hit flag, registered upstream
- `donut_luma`  in  6  renderer luma 0..63, registered upstream
- `hsync_n`  out  1  horizontal sync, active low
- `vsync_n`  out  1  vertical sync, active low
- `de`  out  1  display enable
- `r`, `g`, `b`  out  2 each  pixel colour

## Operation
- Counters: `h_count` increments every clk. At `H_TOTAL-1` it wraps to 0 and `v_count` increments. At `v_count==V_TOTAL-1` with h wrap, `v_count` wraps to 0 and `frame` toggles on the same edge.
- Raw timing, combinational from counters:
  - `de_raw = h<H_DISPLAY && v<V_DISPLAY`
  - `hs_raw` low iff `H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC`
  - `vs_raw` low iff `V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC`
- Delay lines: `de_raw`, `hs_raw`, `vs_raw`, `h[4:3]` and `v[1:0]` pass through shift registers. Syncs and `de` are delayed `LAT` stages. Dither coordinates and the `de` copy used for colour are delayed `LAT-1` stages, then combined in the output register stage.
- Dither:
  - `bayer` is 4-bit standard 4×4 Bayer, indexed by delayed `{v[1:0], h[4:3]}` (row v, column h). Row 0 is 0,8,2,10; row 1 is 12,4,14,6; row 2 is 3,11,1,9; row 3 is 15,7,13,5.
  - `s = {1'b0,donut_luma} + {3'b0,bayer}` (7-bit).
  - `q = s[6] ? 2'd3 : s[5:4]`.
- Colour, registered:
  - delayed de = 0: rgb = 0.
  - else `donut_visible` = 1: r=g=b=q.
  - else (background): r=0, g=0, b=1.
- `donut_visible`/`donut_luma` are sampled every clock. The renderer holds them for ≥8 clocks, so no handshake is needed.

## Timing
- Reset values:
  - `h_count`=0, `v_count`=0, `frame`=0
  - `hsync_n`=1, `vsync_n`=1, `de`=0, rgb=0
  - all delay-line stages hold their inactive value (de 0, syncs 1, coordinates 0).
- Release from reset: the first rising edge increments `h_count` to 1. Pins show the inactive values until the delay lines fill, with no glitch low on the syncs.
- Latency: the pin value at cycle t corresponds to counter value at t-`LAT`. Colour uses donut inputs as sampled at t-1.
- hsync low for exactly `H_SYNC` clocks per line; vsync low for exactly `V_SYNC`×`H_TOTAL` clocks per frame. vsync edges coincide with hsync-relative h=0 (after delay).
- Wrap-around: the h and v wraps and the frame toggle occur on a single edge; no intermediate count of `H_TOTAL` or `V_TOTAL` is ever output.
- Reset asserted mid-frame: all outputs go to reset values immediately (async). Counting restarts from 0,0 with `frame`=0.

## Structure
- Shared package `vga_pkg`:
  - timing constants
  - Bayer 4×4 table as a constant function
  - `rgb2_t` packed struct {r,g,b}
- One sub-module, `delay_line #(WIDTH, DEPTH, RESET_VAL)`: async-reset shift register, instantiated for the sync/de bundle and the coordinate/de-colour bundle.
- Counters, raw timing, dither and output registers stay in `vga_scanout`.

## Test plan
- Reset release, count 1525×525 clocks: `h_count` returns to 0 and `v_count` to 0 exactly once, `frame` toggles 0→1, next frame 1→0.
- Measure hsync_n: low 183 clocks starting 1250+LAT clocks after h=0; line period 1525.
- Measure vsync_n: low for 2 full lines starting at line 490 (delayed by LAT clocks); de high 1220 clocks/line on lines 0..479 only.
- donut_visible=1, luma=0 → rgb 0 at all coordinates. luma=63 → rgb 3 everywhere. luma=32 with bayer 0 → q=2; with bayer 15 → s=47, q=2; luma=40, bayer 8 → s=48, q=3.
- donut_visible=0 during active → r=0,g=0,b=1; during blanking → rgb 0 regardless of inputs.
- Assert rst_n at h=700,v=200, hold 3 clocks: outputs immediately go to reset values; after release, `h_count` resumes 1,2,… from 0 and pins stay inactive for LAT clocks.
